ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF3 (typematic) or 0xFF (reset). It shares the open-drain ps2_clock/ps2_data pins with the existing scancode receiver.

- Sequence: inhibit the bus, issue a request-to-send, shift the byte out on device-generated clock edges, then sample the device ACK.
- Outputs are open-drain enables; the top level builds the tristate.
- `rx_inhibit` lets the keyboard receiver ignore bus activity while a transmission is in progress.

---
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command/handshake and PS/2 pin bundle between a command source and ps2_host_tx.
// slave is the transmitter side; master is the command issuer plus pad logic.
interface ps2_host_tx_if;
  logic       ps2_clock;
  logic       ps2_data;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       ack_ok;
  logic       error;
  logic       rx_inhibit;

  modport master (
    output tx_data, tx_valid, ps2_clock, ps2_data,
    input  tx_ready, done, ack_ok, error, rx_inhibit, ps2_clock_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clock, ps2_data,
    output tx_ready, done, ack_ok, error, rx_inhibit, ps2_clock_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift the
// byte out on device clock falls, then sample the device ACK. Outputs are open-drain enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES    = 5000,
  parameter int DATA_SETUP_CYCLES = 50,
  parameter int TIMEOUT_CYCLES    = 1000000
) (
  input  logic          clk_in,
  input  logic          reset_n,
  ps2_host_tx_if.slave  bus
);

  localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] SETUP_LAST = 20'(DATA_SETUP_CYCLES - 1);
  localparam logic [19:0] TMO_LAST   = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE
  } state_t;

  state_t      state_q;
  logic [19:0] cnt_q;
  logic [19:0] cnt_d;
  logic [3:0]  bit_cnt_q;
  logic [8:0]  sh_q;
  logic [1:0]  clk_sync_q;
  logic [1:0]  dat_sync_q;
  logic        clk_prev_q;
  logic        clock_oe_q;
  logic        data_oe_q;
  logic        tx_ready_q;
  logic        done_q;
  logic        ack_ok_q;
  logic        error_q;
  logic        rx_inhibit_q;

  logic clk_s;
  logic dat_s;
  logic fall;
  logic accept;

  // Synchronizers reset to the idle-high bus level so reset release never looks like a fall.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.ps2_clock};
      dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign dat_s  = dat_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;
  assign accept = bus.tx_valid & tx_ready_q;
  assign cnt_d  = cnt_q + 20'd1;

  // Frame shift register {parity, byte}; pure data, so it carries no reset.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      sh_q <= {~^bus.tx_data, bus.tx_data};
    end else if (state_q == SHIFT && fall && bit_cnt_q <= 4'd8) begin
      sh_q <= {1'b0, sh_q[8:1]};
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      clock_oe_q   <= 1'b0;
      data_oe_q    <= 1'b0;
      tx_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      ack_ok_q     <= 1'b0;
      error_q      <= 1'b0;
      rx_inhibit_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          clock_oe_q   <= 1'b0;
          data_oe_q    <= 1'b0;
          rx_inhibit_q <= 1'b0;
          tx_ready_q   <= 1'b1;
          if (accept) begin
            state_q      <= INHIBIT;
            clock_oe_q   <= 1'b1;
            tx_ready_q   <= 1'b0;
            rx_inhibit_q <= 1'b1;
            ack_ok_q     <= 1'b0;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
          end
        end
        INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            state_q   <= REQ;
            data_oe_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        REQ: begin
          if (cnt_q == SETUP_LAST) begin
            state_q    <= SHIFT;
            clock_oe_q <= 1'b0;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        SHIFT: begin
          if (fall) begin
            cnt_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q <= 4'd8) begin
              data_oe_q <= ~sh_q[0];
            end else if (bit_cnt_q == 4'd9) begin
              data_oe_q <= 1'b0;
            end else begin
              ack_ok_q <= ~dat_s;
              state_q  <= WAIT_IDLE;
            end
          end else if (cnt_q == TMO_LAST) begin
            state_q      <= IDLE;
            error_q      <= 1'b1;
            ack_ok_q     <= 1'b0;
            clock_oe_q   <= 1'b0;
            data_oe_q    <= 1'b0;
            rx_inhibit_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_IDLE: begin
          clock_oe_q <= 1'b0;
          data_oe_q  <= 1'b0;
          if (clk_s && dat_s) begin
            state_q      <= IDLE;
            done_q       <= 1'b1;
            rx_inhibit_q <= 1'b0;
          end else if (fall) begin
            cnt_q <= '0;
          end else if (cnt_q == TMO_LAST) begin
            state_q      <= IDLE;
            error_q      <= 1'b1;
            ack_ok_q     <= 1'b0;
            rx_inhibit_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q      <= IDLE;
          clock_oe_q   <= 1'b0;
          data_oe_q    <= 1'b0;
          rx_inhibit_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ps2_clock_oe = clock_oe_q;
  assign bus.ps2_data_oe  = data_oe_q;
  assign bus.tx_ready     = tx_ready_q;
  assign bus.done         = done_q;
  assign bus.ack_ok       = ack_ok_q;
  assign bus.error        = error_q;
  assign bus.rx_inhibit   = rx_inhibit_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: directed command frames against a PS/2 device model,
// with a scoreboard monitor that checks every done/error pulse against queued expectations.
module tb_ps2_host_tx;
  localparam int INH = 5000;
  localparam int SET = 50;
  localparam int TMO = 2000;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk_pull = 1'b0;
  logic dev_dat_pull = 1'b0;

  always #5 clk_in = ~clk_in;

  ps2_host_tx_if bus();

  assign bus.ps2_clock = ~(bus.ps2_clock_oe | dev_clk_pull);
  assign bus.ps2_data  = ~(bus.ps2_data_oe  | dev_dat_pull);

  ps2_host_tx #(
    .INHIBIT_CYCLES   (INH),
    .DATA_SETUP_CYCLES(SET),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] b;
    logic       par;
    logic       ack;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  logic [9:0] dev_obs = '0;
  logic       hold_mon = 1'b0;
  int         ready_viol = 0;
  int         td, tc, n;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every done/error pulse consumes one expected frame outcome.
  initial begin : monitor
    logic prev_pulse;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk_in);
      if (hold_mon && bus.tx_ready) ready_viol++;
      if (bus.done || bus.error) begin
        chk("pulse_single_cycle", int'(prev_pulse), 0);
        chk("done_error_exclusive", int'(bus.done & bus.error), 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk("error_flag", int'(bus.error), int'(e.is_err));
          chk("ack_ok", int'(bus.ack_ok), int'(e.ack));
          if (!e.is_err) begin
            chk("frame_byte", int'(dev_obs[7:0]), int'(e.b));
            chk("parity_bit", int'(dev_obs[8]), int'(e.par));
            chk("stop_bit", int'(dev_obs[9]), 1);
          end
        end
      end
      prev_pulse = bus.done | bus.error;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input logic hold, input logic [7:0] hold_b);
    int k;
    @(negedge clk_in);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    k = 0;
    while (!bus.tx_ready && k < 20000) begin
      @(negedge clk_in);
      k++;
    end
    chk("ready_before_accept", int'(bus.tx_ready), 1);
    @(negedge clk_in);
    if (hold) bus.tx_data = hold_b;
    else bus.tx_valid = 1'b0;
    chk("clock_oe_after_accept", int'(bus.ps2_clock_oe), 1);
    chk("ready_low_after_accept", int'(bus.tx_ready), 0);
    chk("rx_inhibit_active", int'(bus.rx_inhibit), 1);
    chk("ack_cleared_on_accept", int'(bus.ack_ok), 0);
  endtask

  // Device model. mode 0: ACK, 1: no ACK, 2: never clocks. Called on the negedge after accept.
  task automatic dev_frame(input int mode, input int nfalls, output int t_drise, output int t_cfall);
    int k;
    k = 1;
    t_drise = -1;
    while (bus.ps2_clock_oe && k < 20000) begin
      if (bus.ps2_data_oe && t_drise < 0) t_drise = k;
      @(negedge clk_in);
      k++;
    end
    t_cfall = k;
    chk("start_bit_low", int'(bus.ps2_data_oe), 1);
    if (mode == 2) return;
    repeat (10) @(negedge clk_in);
    for (int i = 0; i < nfalls; i++) begin
      dev_clk_pull = 1'b1;
      repeat (20) @(negedge clk_in);
      if (nfalls < 10 && i == nfalls - 1) return;
      dev_clk_pull = 1'b0;
      repeat (10) @(negedge clk_in);
      dev_obs[i] = bus.ps2_data;
      repeat (10) @(negedge clk_in);
    end
    if (mode == 0) dev_dat_pull = 1'b1;
    repeat (5) @(negedge clk_in);
    dev_clk_pull = 1'b1;
    repeat (20) @(negedge clk_in);
    dev_clk_pull = 1'b0;
    if (mode == 0) begin
      repeat (5) @(negedge clk_in);
      dev_dat_pull = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!(bus.done || bus.error) && k < 2000) begin
      @(negedge clk_in);
      k++;
    end
    hold_mon = 1'b0;
    chk("done_seen", int'(bus.done | bus.error), 1);
    chk("ready_low_during_done", int'(bus.tx_ready), 0);
    @(negedge clk_in);
    chk("ready_after_done", int'(bus.tx_ready), 1);
    chk("rx_inhibit_after_done", int'(bus.rx_inhibit), 0);
  endtask

  initial begin : stimulus
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk_in);
    chk("rst_clock_oe", int'(bus.ps2_clock_oe), 0);
    chk("rst_data_oe", int'(bus.ps2_data_oe), 0);
    chk("rst_tx_ready", int'(bus.tx_ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ack_ok", int'(bus.ack_ok), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_rx_inhibit", int'(bus.rx_inhibit), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_in);

    // 0xED with ACK; request timing measured on the same frame
    send(8'hED, 1'b0, 8'h00);
    sb_q.push_back('{1'b0, 8'hED, 1'b1, 1'b1});
    dev_frame(0, 10, td, tc);
    chk("data_oe_rise_index", td, INH + 1);
    chk("clock_oe_fall_index", tc, INH + SET + 1);
    wait_done();
    repeat (20) @(negedge clk_in);
    chk("ack_ok_holds", int'(bus.ack_ok), 1);

    // 0xFF, device leaves data high at edge 11
    send(8'hFF, 1'b0, 8'h00);
    sb_q.push_back('{1'b0, 8'hFF, 1'b1, 1'b0});
    dev_frame(1, 10, td, tc);
    wait_done();

    // 0xF4 has an odd number of ones, so its parity bit is 0
    send(8'hF4, 1'b0, 8'h00);
    sb_q.push_back('{1'b0, 8'hF4, 1'b0, 1'b1});
    dev_frame(0, 10, td, tc);
    wait_done();

    // device never clocks
    send(8'h5A, 1'b0, 8'h00);
    sb_q.push_back('{1'b1, 8'h5A, 1'b0, 1'b0});
    dev_frame(2, 10, td, tc);
    n = 0;
    while (!bus.error && n < TMO + 100) begin
      @(negedge clk_in);
      n++;
    end
    chk("timeout_cycles", n, TMO);
    @(negedge clk_in);
    chk("timeout_clock_oe", int'(bus.ps2_clock_oe), 0);
    chk("timeout_data_oe", int'(bus.ps2_data_oe), 0);
    chk("timeout_tx_ready", int'(bus.tx_ready), 1);

    // tx_valid held with 0xF3 during a 0xED frame
    send(8'hED, 1'b1, 8'hF3);
    sb_q.push_back('{1'b0, 8'hED, 1'b1, 1'b1});
    hold_mon = 1'b1;
    dev_frame(0, 10, td, tc);
    wait_done();
    chk("ready_low_while_busy", ready_viol, 0);
    sb_q.push_back('{1'b0, 8'hF3, 1'b1, 1'b1});
    @(negedge clk_in);
    bus.tx_valid = 1'b0;
    chk("f3_accepted_after_done", int'(bus.ps2_clock_oe), 1);
    dev_frame(0, 10, td, tc);
    wait_done();

    // asynchronous reset after fall 5
    send(8'hED, 1'b0, 8'h00);
    dev_frame(0, 5, td, tc);
    chk("bit4_driven_low", int'(bus.ps2_data_oe), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_clock_oe", int'(bus.ps2_clock_oe), 0);
    chk("async_rst_data_oe", int'(bus.ps2_data_oe), 0);
    @(negedge clk_in);
    dev_clk_pull = 1'b0;
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    chk("ready_after_reset", int'(bus.tx_ready), 1);
    chk("rx_inhibit_after_reset", int'(bus.rx_inhibit), 0);
    repeat (50) @(negedge clk_in);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
